// File: rtl/peripheral_noc_vc_buffer_pkg.sv
// peripheral_noc_pkg: flit layout and arbiter state shared by the NoC VC buffer.
package peripheral_noc_pkg;
  localparam int FLIT_W = 32;
  typedef struct packed {
    logic              last;
    logic [FLIT_W-1:0] data;
  } flit_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/peripheral_noc_vc_buffer_fifo.sv
// peripheral_noc_vc_fifo: one virtual-channel RAM FIFO with occupancy and complete-packet counters.
module peripheral_noc_vc_fifo
  import peripheral_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_push_last,
  input  logic [FLIT_WIDTH-1:0] i_push_flit,
  input  logic                  i_pop,
  output logic [FLIT_WIDTH-1:0] o_head_flit,
  output logic                  o_head_last,
  output logic [AW:0]           o_fill,
  output logic                  o_has_pkt
);
  typedef struct packed {
    logic                  last;
    logic [FLIT_WIDTH-1:0] data;
  } vc_flit_t;
  vc_flit_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_fill, r_pkt;
  logic            w_push_eop, w_pop_eop;
  assign w_push_eop  = i_push & i_push_last;
  assign w_pop_eop   = i_pop & r_mem[r_rp].last;
  assign o_head_flit = r_mem[r_rp].data;
  assign o_head_last = r_mem[r_rp].last;
  assign o_fill      = r_fill;
  assign o_has_pkt   = r_pkt != '0;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= '{last: i_push_last, data: i_push_flit};
  // Pointers wrap naturally at AW bits; callers never push when full or pop when empty.
  always_ff @(posedge clk)
    if (!rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fill <= '0;
      r_pkt  <= '0;
    end else begin
      r_wp   <= r_wp + AW'(i_push);
      r_rp   <= r_rp + AW'(i_pop);
      r_fill <= r_fill + (AW+1)'(i_push) - (AW+1)'(i_pop);
      r_pkt  <= r_pkt + (AW+1)'(w_push_eop) - (AW+1)'(w_pop_eop);
    end
endmodule

// File: rtl/peripheral_noc_vc_buffer.sv
// peripheral_noc_vc_buffer: multi-VC flit buffer with a packet-locked round-robin output arbiter.
module peripheral_noc_vc_buffer
  import peripheral_noc_pkg::*;
#(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2,
  parameter int DEPTH      = 8,
  parameter int FULLPACKET = 0,
  parameter int AW         = $clog2(DEPTH),
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_WIDTH-1:0]      in_flit,
  input  logic                       in_last,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  output logic [FLIT_WIDTH-1:0]      out_flit,
  output logic                       out_last,
  output logic                       out_valid,
  output logic [CW-1:0]              out_channel,
  input  logic                       out_ready,
  output logic [CHANNELS*(AW+1)-1:0] fill_level
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 2");
  end
  logic [CHANNELS-1:0]   w_req, w_push, w_pop, w_has_pkt, w_head_last;
  logic [FLIT_WIDTH-1:0] w_head_flit [CHANNELS];
  logic [AW:0]           w_fill      [CHANNELS];
  arb_state_e            r_state, w_state_nxt;
  logic [CW-1:0]         r_grant, w_grant, r_rr;
  logic                  w_xfer;
  // A multi-hot in_valid is a protocol error: nothing is accepted that cycle.
  assign w_push = in_valid & in_ready & {CHANNELS{$onehot0(in_valid)}};
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign in_ready[c] = w_fill[c] != (AW+1)'(DEPTH);
    assign w_req[c]    = (FULLPACKET != 0) ? w_has_pkt[c] : w_fill[c] != '0;
    assign w_pop[c]    = w_xfer && w_grant == CW'(c);
    assign fill_level[c*(AW+1) +: AW+1] = w_fill[c];
    peripheral_noc_vc_fifo #(.FLIT_WIDTH(FLIT_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push[c]),
      .i_push_last(in_last),
      .i_push_flit(in_flit),
      .i_pop      (w_pop[c]),
      .o_head_flit(w_head_flit[c]),
      .o_head_last(w_head_last[c]),
      .o_fill     (w_fill[c]),
      .o_has_pkt  (w_has_pkt[c])
    );
    if (FULLPACKET != 0) begin : g_fp_chk
      a_pkt_fits: assert property (@(posedge clk) disable iff (!rst)
        !(w_fill[c] == (AW+1)'(DEPTH) && !w_has_pkt[c]));
    end
  end
  a_onehot_valid: assert property (@(posedge clk) disable iff (!rst) $onehot0(in_valid));
  // Descending scan so the lowest offset from rr_ptr wins; no request keeps the previous grant.
  always_comb begin
    w_grant = r_grant;
    if (r_state == IDLE)
      for (int i = CHANNELS - 1; i >= 0; i--)
        if (w_req[(int'(r_rr) + i) % CHANNELS]) w_grant = CW'((int'(r_rr) + i) % CHANNELS);
    out_channel = w_grant;
    out_flit    = w_head_flit[w_grant];
    out_last    = w_head_last[w_grant];
    out_valid   = w_req[w_grant];
    w_xfer      = out_valid & out_ready;
    w_state_nxt = w_xfer ? (out_last ? IDLE : LOCKED) : r_state;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant;
      if (w_xfer && out_last) r_rr <= (w_grant == CW'(CHANNELS - 1)) ? '0 : w_grant + 1'b1;
    end
endmodule

// File: tb/tb_peripheral_noc_vc_buffer.sv
// tb_peripheral_noc_vc_buffer: directed vector table plus hand sequences for the VC buffer.
module tb_peripheral_noc_vc_buffer;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] in_flit, out_flit, fp_in_flit, fp_out_flit;
  logic        in_last, out_last, out_valid, out_ready;
  logic        fp_in_last, fp_out_last, fp_out_valid, fp_out_ready;
  logic [1:0]  in_valid, in_ready, fp_in_valid, fp_in_ready;
  logic [0:0]  out_channel, fp_out_channel;
  logic [7:0]  fill_level, fp_fill_level;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  peripheral_noc_vc_buffer u_dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid),
    .out_channel(out_channel), .out_ready(out_ready), .fill_level(fill_level)
  );

  peripheral_noc_vc_buffer #(.FULLPACKET(1)) u_fp (
    .clk(clk), .rst(rst), .in_flit(fp_in_flit), .in_last(fp_in_last), .in_valid(fp_in_valid),
    .in_ready(fp_in_ready), .out_flit(fp_out_flit), .out_last(fp_out_last),
    .out_valid(fp_out_valid), .out_channel(fp_out_channel), .out_ready(fp_out_ready),
    .fill_level(fp_fill_level)
  );

  typedef struct {
    logic [1:0]  v;
    logic [31:0] flit;
    logic        last;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_flit;
    logic        e_last;
    logic        e_ch;
    logic [3:0]  e_f0;
    logic [3:0]  e_f1;
  } vec_t;
  vec_t q[$];

  task automatic add(input logic [1:0] v, input logic [31:0] flit, input logic last,
                     input logic ordy, input logic e_ov, input logic [31:0] e_flit,
                     input logic e_last, input logic e_ch, input logic [3:0] e_f0,
                     input logic [3:0] e_f1);
    q.push_back('{v, flit, last, ordy, e_ov, e_flit, e_last, e_ch, e_f0, e_f1});
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; in_flit = '0; in_last = 0; out_ready = 0;
    fp_in_valid = '0; fp_in_flit = '0; fp_in_last = 0; fp_out_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    repeat (2) tick();
    rst = 1;
  endtask

  initial begin
    idle();
    // reset held with a pending write must not store anything
    in_valid = 2'b01; in_flit = 32'hAA; in_last = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst%0d in_ready", k), in_ready, 2'b11);
      chk($sformatf("rst%0d out_valid", k), out_valid, 0);
      chk($sformatf("rst%0d fill", k), fill_level, 0);
    end
    rst = 1;
    tick();
    in_valid = '0;
    chk("post_rst valid", out_valid, 1);
    chk("post_rst flit", out_flit, 32'hAA);
    chk("post_rst chan", out_channel, 0);
    chk("post_rst fill", fill_level, 8'h01);

    // fill channel 1 to DEPTH, try a write while full and being read, then drain
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = 2'b10; in_flit = 32'h10 + k; in_last = (k == 7);
      chk($sformatf("fill%0d in_ready1", k), in_ready[1], 1);
      tick();
    end
    in_valid = '0;
    chk("full in_ready", in_ready, 2'b01);
    chk("full fill", fill_level, 8'h80);
    in_valid = 2'b10; in_flit = 32'h99; in_last = 0; out_ready = 1;
    chk("drain0 valid", out_valid, 1);
    chk("drain0 flit", out_flit, 32'h10);
    chk("drain0 chan", out_channel, 1);
    tick();
    in_valid = '0;
    chk("no_passthru fill", fill_level, 8'h70);
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("drain%0d valid", k), out_valid, 1);
      chk($sformatf("drain%0d flit", k), out_flit, 32'h10 + k);
      chk($sformatf("drain%0d chan", k), out_channel, 1);
      chk($sformatf("drain%0d last", k), out_last, k == 7);
      tick();
    end
    chk("drained valid", out_valid, 0);
    chk("drained fill", fill_level, 0);

    // two 3-flit packets, round-robin, then lock hold across an input bubble
    do_reset();
    add(2'b01, 32'hA0, 0, 0, 0, 0,      0, 0, 0, 0);
    add(2'b10, 32'hB0, 0, 0, 1, 32'hA0, 0, 0, 1, 0);
    add(2'b01, 32'hA1, 0, 0, 1, 32'hA0, 0, 0, 1, 1);
    add(2'b10, 32'hB1, 0, 0, 1, 32'hA0, 0, 0, 2, 1);
    add(2'b01, 32'hA2, 1, 0, 1, 32'hA0, 0, 0, 2, 2);
    add(2'b10, 32'hB2, 1, 0, 1, 32'hA0, 0, 0, 3, 2);
    add(2'b00, 0,      0, 1, 1, 32'hA0, 0, 0, 3, 3);
    add(2'b00, 0,      0, 1, 1, 32'hA1, 0, 0, 2, 3);
    add(2'b00, 0,      0, 1, 1, 32'hA2, 1, 0, 1, 3);
    add(2'b00, 0,      0, 1, 1, 32'hB0, 0, 1, 0, 3);
    add(2'b00, 0,      0, 1, 1, 32'hB1, 0, 1, 0, 2);
    add(2'b00, 0,      0, 1, 1, 32'hB2, 1, 1, 0, 1);
    add(2'b10, 32'hC0, 1, 0, 0, 0,      0, 1, 0, 0);
    add(2'b01, 32'hD0, 1, 0, 1, 32'hC0, 1, 1, 0, 1);
    add(2'b00, 0,      0, 1, 1, 32'hD0, 1, 0, 1, 1);
    add(2'b00, 0,      0, 1, 1, 32'hC0, 1, 1, 0, 1);
    add(2'b10, 32'hF0, 1, 0, 0, 0,      0, 1, 0, 0);
    add(2'b01, 32'hE0, 0, 0, 1, 32'hF0, 1, 1, 0, 1);
    add(2'b01, 32'hE1, 0, 1, 1, 32'hE0, 0, 0, 1, 1);
    add(2'b00, 0,      0, 1, 1, 32'hE1, 0, 0, 1, 1);
    add(2'b00, 0,      0, 1, 0, 0,      0, 0, 0, 1);
    add(2'b01, 32'hE2, 0, 1, 0, 0,      0, 0, 0, 1);
    add(2'b01, 32'hE3, 1, 1, 1, 32'hE2, 0, 0, 1, 1);
    add(2'b00, 0,      0, 1, 1, 32'hE3, 1, 0, 1, 1);
    add(2'b00, 0,      0, 1, 1, 32'hF0, 1, 1, 0, 1);
    add(2'b00, 0,      0, 0, 0, 0,      0, 1, 0, 0);
    foreach (q[i]) begin
      in_valid = q[i].v; in_flit = q[i].flit; in_last = q[i].last; out_ready = q[i].ordy;
      chk($sformatf("row%0d valid", i), out_valid, q[i].e_ov);
      chk($sformatf("row%0d chan", i), out_channel, q[i].e_ch);
      chk($sformatf("row%0d fill", i), fill_level, {q[i].e_f1, q[i].e_f0});
      if (q[i].e_ov) begin
        chk($sformatf("row%0d flit", i), out_flit, q[i].e_flit);
        chk($sformatf("row%0d last", i), out_last, q[i].e_last);
      end
      tick();
    end

    // FULLPACKET: nothing offered until the packet's last flit is stored
    do_reset();
    fp_out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      fp_in_valid = 2'b01; fp_in_flit = 32'h50 + k; fp_in_last = (k == 3);
      chk($sformatf("fp_wr%0d valid", k), fp_out_valid, 0);
      chk($sformatf("fp_wr%0d fill", k), fp_fill_level, k);
      tick();
    end
    fp_in_valid = '0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fp_rd%0d valid", k), fp_out_valid, 1);
      chk($sformatf("fp_rd%0d flit", k), fp_out_flit, 32'h50 + k);
      chk($sformatf("fp_rd%0d last", k), fp_out_last, k == 3);
      tick();
    end
    chk("fp_done valid", fp_out_valid, 0);

    // steady push/pop at fill 1 across several pointer wraps
    do_reset();
    in_valid = 2'b01; in_flit = 32'h600; in_last = 1;
    tick();
    out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      in_flit = 32'h601 + k;
      chk($sformatf("pp%0d valid", k), out_valid, 1);
      chk($sformatf("pp%0d flit", k), out_flit, 32'h600 + k);
      chk($sformatf("pp%0d fill", k), fill_level, 8'h01);
      tick();
    end
    in_valid = '0;
    chk("pp_end flit", out_flit, 32'h614);
    chk("pp_end fill", fill_level, 8'h01);
    tick();
    chk("pp_empty fill", fill_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
